// File: rtl/addsub_op_sequencer.sv
// rtl/addsub_op_sequencer.sv - issues one command to the registered add/sub datapath and returns its Z/Overflow
// Define ADDSUB_SEQ_SAT_EN to saturate out_z whenever the captured overflow is set.
module addsub_op_sequencer #(
  parameter int N   = 16,
  parameter int LAT = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] as_a,
  output logic [N-1:0] as_b,
  output logic         as_sel,
  output logic         as_addsub,
  input  logic [N-1:0] as_z,
  input  logic         as_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_z,
  output logic         out_ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky,
  output logic [15:0]  op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int            CW       = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  out_z_q, out_z_d;
  logic          out_ovf_q, out_ovf_d;
  logic          sticky_q, sticky_d;
  logic [15:0]   count_q, count_d;
  logic [N-1:0]  cap_z;
  logic          capture;

`ifdef ADDSUB_SEQ_SAT_EN
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  // A set MSB on overflow means the true result was positive and wrapped negative.
  always_comb begin
    cap_z = as_z;
    if (as_ovf) begin
      cap_z = as_z[N-1] ? MAX_POS : MIN_NEG;
    end
  end
`else
  always_comb begin
    cap_z = as_z;
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_z_q   <= '0;
      out_ovf_q <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_z_q   <= out_z_d;
      out_ovf_q <= out_ovf_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CAPTURE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign capture = (state_q == S_CAPTURE);

  // Command/result registers; a coincident clr_sticky beats the capture increment.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    out_z_d   = out_z_q;
    out_ovf_d = out_ovf_q;
    sticky_d  = clr_sticky ? 1'b0 : sticky_q;
    count_d   = count_q;
    if (state_q == S_IDLE && in_valid) begin
      op_d = in_op;
      a_d  = in_a;
      b_d  = in_b;
    end
    if (capture) begin
      out_z_d   = cap_z;
      out_ovf_d = as_ovf;
      sticky_d  = sticky_d | as_ovf;
      count_d   = count_q + 16'd1;
    end
    if (clr_sticky) begin
      count_d = '0;
    end
  end

  // Outside ISSUE the datapath sees Z+0, which preserves the accumulator and clears Overflow.
  always_comb begin
    as_sel    = 1'b1;
    as_addsub = 1'b0;
    as_a      = '0;
    as_b      = '0;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    if (state_q == S_ISSUE) begin
      as_sel    = op_q[1];
      as_addsub = op_q[0];
      as_a      = op_q[1] ? '0 : a_q;
      as_b      = b_q;
    end
  end

  assign out_z      = out_z_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// tb/tb_addsub_op_sequencer.sv - scoreboard bench for addsub_op_sequencer against a registered add/sub datapath model
module tb_addsub_op_sequencer;
  localparam int N   = 16;
  localparam int LAT = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic [N-1:0]  as_a, as_b;
  logic          as_sel, as_addsub;
  logic [N-1:0]  as_z;
  logic          as_ovf;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_z;
  logic          out_ovf;
  logic          ovf_sticky;
  logic          clr_sticky = 1'b0;
  logic [15:0]   op_count;

  always #5 Clock = ~Clock;

  addsub_op_sequencer #(.N(N), .LAT(LAT)) dut (
    .Clock(Clock), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .as_a(as_a), .as_b(as_b), .as_sel(as_sel), .as_addsub(as_addsub),
    .as_z(as_z), .as_ovf(as_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  // Datapath: operands registered, then Z/Overflow registered, Z fed back as accumulator.
  logic [15:0] dp_a, dp_b, dp_z, dp_x, dp_bb, dp_sum;
  logic        dp_sel, dp_sub, dp_ovf;
  always_comb begin
    dp_x   = dp_sel ? dp_z : dp_a;
    dp_bb  = dp_sub ? ~dp_b : dp_b;
    dp_sum = dp_x + dp_bb + {15'd0, dp_sub};
  end
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dp_a <= '0; dp_b <= '0; dp_sel <= 1'b0; dp_sub <= 1'b0; dp_z <= '0; dp_ovf <= 1'b0;
    end else begin
      dp_a <= as_a; dp_b <= as_b; dp_sel <= as_sel; dp_sub <= as_addsub;
      dp_z <= dp_sum;
      dp_ovf <= (dp_x[15] == dp_bb[15]) && (dp_sum[15] != dp_x[15]);
    end
  end
  assign as_z   = dp_z;
  assign as_ovf = dp_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] z;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] exp_acc    = '0;
  int          exp_count  = 0;
  logic        exp_sticky = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic predict(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit clr_cap);
    int   xi, bi, ri;
    exp_t e;
    xi = op[1] ? int'($signed(exp_acc)) : int'($signed(a));
    bi = int'($signed(b));
    ri = op[0] ? xi - bi : xi + bi;
    e.ovf = (ri > 32767) || (ri < -32768);
    exp_acc = ri[15:0];
    e.z = exp_acc;
`ifdef ADDSUB_SEQ_SAT_EN
    if (e.ovf) e.z = exp_acc[15] ? 16'h7FFF : 16'h8000;
`endif
    exp_q.push_back(e);
    exp_count  = clr_cap ? 0 : (exp_count + 1) & 16'hFFFF;
    exp_sticky = clr_cap ? e.ovf : (exp_sticky | e.ovf);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input bit clr_cap);
    exp_t e;
    int   n;
    predict(op, a, b, clr_cap);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin tick; n++; end
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick;
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
    check_eq("in_ready_busy", in_ready, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      if (clr_cap && n == LAT) clr_sticky = 1'b1;
      tick;
      n++;
      clr_sticky = 1'b0;
    end
    check_eq("latency", n, LAT + 1);
    check_eq("sb_size", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("out_z", out_z, e.z);
      check_eq("out_ovf", out_ovf, e.ovf);
      check_eq("op_count", op_count, exp_count);
      check_eq("ovf_sticky", ovf_sticky, exp_sticky);
      check_eq("in_ready_done", in_ready, 0);
      for (int i = 0; i < stall; i++) begin
        tick;
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_z", out_z, e.z);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_hold", {as_sel, as_addsub, |as_a, |as_b}, 4'b1000);
      end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_eq("consumed", out_valid, 0);
    check_eq("idle_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out", {out_z, out_ovf, ovf_sticky}, 0);
    check_eq("rst_count", op_count, 0);
    check_eq("rst_hold", {as_sel, as_addsub, |as_a, |as_b}, 4'b1000);
    Reset = 1'b0;
    tick;

    run_op(2'b00, 16'h0003, 16'h0004, 0, 1'b0);
    run_op(2'b11, 16'hAAAA, 16'h0002, 0, 1'b0);
    run_op(2'b10, 16'h5555, 16'h0010, 0, 1'b0);
    run_op(2'b00, 16'h7FFF, 16'h0001, 0, 1'b0);
    run_op(2'b00, 16'h0001, 16'h0001, 6, 1'b0);
    run_op(2'b10, 16'hFFFF, 16'h0000, 0, 1'b0);

    // Abort an op while it is in WAIT.
    in_valid = 1'b1; in_op = 2'b00; in_a = 16'h0005; in_b = 16'h0006;
    tick;
    in_valid = 1'b0;
    tick;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    exp_acc = '0; exp_count = 0; exp_sticky = 1'b0;
    tick;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_ready", in_ready, 1);
    check_eq("midrst_count", op_count, 0);
    check_eq("midrst_sticky", ovf_sticky, 0);
    run_op(2'b10, 16'h1234, 16'h0009, 0, 1'b0);

    run_op(2'b00, 16'h7FFF, 16'h0001, 0, 1'b1);
    run_op(2'b01, 16'h8000, 16'h0001, 1, 1'b0);

    clr_sticky = 1'b1;
    tick;
    clr_sticky = 1'b0;
    exp_count = 0; exp_sticky = 1'b0;
    check_eq("clr_count", op_count, 0);
    check_eq("clr_sticky", ovf_sticky, 0);

    for (int k = 0; k < 10; k++) begin
      run_op(2'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
